// File: rtl/ahb_slave_mem_if.sv
// ahb_slave_mem_if: AHB bus signal bundle shared by master agents and slaves.
// The master modport drives the address/data phase; the slave returns the response.
interface ahb_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [1:0]            htrans;
  logic                  hreadyin;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hreadyout;
  logic [1:0]            hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  modport master (
    output hsel,
    output haddr,
    output hwrite,
    output hsize,
    output hburst,
    output htrans,
    output hreadyin,
    output hwdata,
    input  hreadyout,
    input  hresp,
    input  hrdata
  );

  modport slave (
    input  hsel,
    input  haddr,
    input  hwrite,
    input  hsize,
    input  hburst,
    input  htrans,
    input  hreadyin,
    input  hwdata,
    output hreadyout,
    output hresp,
    output hrdata
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB slave memory with programmable wait states and byte lanes.
// AHB_SLV_ERR_RESP_EN enables the two-cycle ERROR response for bad accesses.
module ahb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic           hclk,
  input  logic           hresetn,
  ahb_slave_mem_if.slave bus
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);
  localparam int AW  = LSB + IW;
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(DEPTH * NB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA
`ifdef AHB_SLV_ERR_RESP_EN
    ,
    S_ERR1,
    S_ERR2
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [2:0]      size_q, size_d;
  logic            oor_q, oor_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic            accept;
  logic            open;
  logic            take;
  logic            oor_in;
  logic            big_in;
  logic [2:0]      size_in;
  logic [IW-1:0]   idx;
  logic [LSB-1:0]  amask;
  logic [LSB-1:0]  off;
  logic [NB-1:0]   strb;
  logic            we;
  logic            rd_en;
  logic            ready;
  logic [1:0]      resp;
  logic            unused_w;

  assign accept = bus.hsel & bus.hreadyin
                & bus.htrans[1];

`ifdef AHB_SLV_ERR_RESP_EN
  assign open = (state_q == S_IDLE)
              | (state_q == S_DATA)
              | (state_q == S_ERR2);
`else
  assign open = (state_q == S_IDLE)
              | (state_q == S_DATA);
`endif

  assign take   = accept & open;
  assign oor_in = {1'b0, bus.haddr} >= LIMIT;
  assign big_in = bus.hsize > 3'(LSB);

`ifdef AHB_SLV_ERR_RESP_EN
  assign size_in = bus.hsize;
`else
  // Oversize requests degrade to a full-width access.
  assign size_in = big_in ? 3'(LSB) : bus.hsize;
`endif

  assign unused_w = ^{bus.hburst, bus.htrans[0]};

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      oor_q   <= oor_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    oor_d   = oor_q;
    unique case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_DATA;
      end
`ifdef AHB_SLV_ERR_RESP_EN
      S_ERR1: state_d = S_ERR2;
`endif
      default: state_d = S_IDLE;
    endcase
    // DATA/ERR2 overlap the next address phase.
    if (take) begin
      addr_d  = bus.haddr[AW-1:0];
      write_d = bus.hwrite;
      size_d  = size_in;
      oor_d   = oor_in;
`ifdef AHB_SLV_ERR_RESP_EN
      if (oor_in | big_in) begin
        state_d = S_ERR1;
        cnt_d   = '0;
      end else
`endif
      if (WAIT_STATES == 0) begin
        state_d = S_DATA;
        cnt_d   = '0;
      end else begin
        state_d = S_WAIT;
        cnt_d   = 4'(WAIT_STATES);
      end
    end
  end

  always_comb begin
    ready = 1'b1;
    resp  = 2'b00;
    unique case (state_q)
      S_WAIT: ready = 1'b0;
`ifdef AHB_SLV_ERR_RESP_EN
      S_ERR1: begin
        ready = 1'b0;
        resp  = 2'b01;
      end
      S_ERR2: resp = 2'b01;
`endif
      default: ;
    endcase
  end

  assign idx = addr_q[LSB +: IW];

  // Lane b is hit when it shares the size-aligned group of the address.
  always_comb begin
    amask = '1;
    for (int s = 0; s < LSB; s++)
      if (s < int'(size_q)) amask[s] = 1'b0;
    off  = addr_q[LSB-1:0] & amask;
    strb = '0;
    for (int b = 0; b < NB; b++)
      if ((b[LSB-1:0] & amask) == off)
        strb[b] = 1'b1;
  end

  assign we = hresetn & (state_q == S_DATA)
            & write_q & ~oor_q;

  assign rd_en = (state_q == S_DATA)
               & ~write_q & ~oor_q;

  always_ff @(posedge hclk) begin
    if (we) begin
      for (int b = 0; b < NB; b++)
        if (strb[b])
          mem_q[idx][8*b +: 8] <= bus.hwdata[8*b +: 8];
    end
  end

  assign bus.hreadyout = ready;
  assign bus.hresp     = resp;
  assign bus.hrdata    = rd_en ? mem_q[idx] : '0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: pipelined AHB master driving two slaves (0 and 3 waits).
// Expectations are queued at address accept and checked at data completion.
module tb_ahb_slave_mem;
  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] BZ  = 2'b01;
  localparam logic [1:0] NS  = 2'b10;
  localparam logic [1:0] SQ  = 2'b11;
`ifdef AHB_SLV_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [1:0] ERR = ERR_EN ? 2'b01 : 2'b00;

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          waits;
  } beat_t;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        sel;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        rdy;
  logic [1:0]  resp;
  logic [31:0] rdata;

  int n_vec = 0;
  int n_err = 0;

  beat_t prog[$];
  beat_t sb[$];

  ahb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
  ahb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b3 ();

  assign b0.hsel     = hsel & ~sel;
  assign b0.haddr    = haddr;
  assign b0.hwrite   = hwrite;
  assign b0.hsize    = hsize;
  assign b0.hburst   = hburst;
  assign b0.htrans   = htrans;
  assign b0.hwdata   = hwdata;
  assign b0.hreadyin = b0.hreadyout;

  assign b3.hsel     = hsel & sel;
  assign b3.haddr    = haddr;
  assign b3.hwrite   = hwrite;
  assign b3.hsize    = hsize;
  assign b3.hburst   = hburst;
  assign b3.htrans   = htrans;
  assign b3.hwdata   = hwdata;
  assign b3.hreadyin = b3.hreadyout;

  assign rdy   = sel ? b3.hreadyout : b0.hreadyout;
  assign resp  = sel ? b3.hresp     : b0.hresp;
  assign rdata = sel ? b3.hrdata    : b0.hrdata;

  ahb_slave_mem #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .DEPTH(1024), .WAIT_STATES(0)
  ) u0 (
    .hclk(hclk), .hresetn(hresetn), .bus(b0)
  );

  ahb_slave_mem #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .DEPTH(1024), .WAIT_STATES(3)
  ) u3 (
    .hclk(hclk), .hresetn(hresetn), .bus(b3)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input logic [1:0] t,
                               input logic w,
                               input logic [2:0] s,
                               input logic [31:0] a,
                               input logic [31:0] wd,
                               input logic [31:0] rd,
                               input logic [1:0] r);
    beat_t b;
    b.trans = t;
    b.wr    = w;
    b.size  = s;
    b.addr  = a;
    b.wdata = wd;
    b.rdata = rd;
    b.resp  = r;
    b.waits = 0;
    return b;
  endfunction

  task automatic add(input logic [1:0] t, input logic w,
                     input logic [2:0] s, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input logic [1:0] r);
    prog.push_back(mk(t, w, s, a, wd, rd, r));
  endtask

  // Runs prog as a pipelined master; call at posedge+1.
  task automatic run_prog(input int ws);
    int    idx;
    int    waits;
    bit    busy;
    beat_t b;
    beat_t dp;
    beat_t ex;
    idx   = 0;
    waits = 0;
    busy  = 1'b0;
    while ((idx < prog.size()) || busy) begin
      if (idx < prog.size()) begin
        b      = prog[idx];
        htrans = b.trans;
        hwrite = b.wr;
        hsize  = b.size;
        haddr  = b.addr;
      end else begin
        htrans = IDL;
        hwrite = 1'b0;
        hsize  = 3'd2;
        haddr  = '0;
      end
      hwdata = busy ? dp.wdata : '0;
      @(negedge hclk);
      if (busy) begin
        if (!rdy) begin
          chk("resp_stall", {30'd0, resp}, {30'd0, dp.resp});
          waits++;
          if (waits > 32) begin
            chk("timeout", waits, 0);
            sb.delete();
            busy = 1'b0;
            idx  = prog.size();
          end
        end else begin
          ex = sb.pop_front();
          chk("resp", {30'd0, resp}, {30'd0, ex.resp});
          chk("waits", waits, ex.waits);
          chk("rdata", rdata, ex.rdata);
          busy = 1'b0;
        end
      end
      if (rdy && (idx < prog.size())) begin
        b = prog[idx];
        if (!b.trans[1]) b.waits = 0;
        else if (b.resp == 2'b01) b.waits = 1;
        else b.waits = ws;
        sb.push_back(b);
        dp    = b;
        busy  = 1'b1;
        waits = 0;
        idx++;
      end
      @(posedge hclk);
      #1;
    end
    htrans = IDL;
    hwrite = 1'b0;
    hwdata = '0;
    prog.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    hresetn = 1'b0;
    sel     = 1'b0;
    hsel    = 1'b1;
    haddr   = '0;
    hwrite  = 1'b0;
    hsize   = 3'd2;
    hburst  = 3'd0;
    htrans  = IDL;
    hwdata  = '0;

    repeat (3) @(posedge hclk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_ready", {31'd0, rdy}, 32'd1);
      chk("rst_resp", {30'd0, resp}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
    end
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;

    // zero-wait slave: back-to-back, halfword lanes
    sel = 1'b0;
    add(NS, 1, 2, 32'h10, 32'hDEADBEEF, 0, 0);
    add(NS, 0, 2, 32'h10, 0, 32'hDEADBEEF, 0);
    add(NS, 1, 2, 32'h14, 32'h01020304, 0, 0);
    add(NS, 1, 1, 32'h16, 32'hBEEFCAFE, 0, 0);
    add(NS, 0, 2, 32'h14, 0, 32'hBEEF0304, 0);
    add(NS, 1, 0, 32'h14, 32'h5A5A5A5A, 0, 0);
    add(NS, 0, 2, 32'h14, 0, 32'hBEEF035A, 0);
    run_prog(0);

    // INCR4 with a BUSY beat that must not write
    add(NS, 1, 2, 32'h30, 32'h30303030, 0, 0);
    run_prog(0);
    hburst = 3'b011;
    add(NS, 1, 2, 32'h20, 32'hA0A0A0A0, 0, 0);
    add(SQ, 1, 2, 32'h24, 32'hA1A1A1A1, 0, 0);
    add(BZ, 1, 2, 32'h30, 32'hFFFFFFFF, 0, 0);
    add(SQ, 1, 2, 32'h28, 32'hA2A2A2A2, 0, 0);
    add(SQ, 1, 2, 32'h2C, 32'hA3A3A3A3, 0, 0);
    add(NS, 0, 2, 32'h20, 0, 32'hA0A0A0A0, 0);
    add(SQ, 0, 2, 32'h24, 0, 32'hA1A1A1A1, 0);
    add(SQ, 0, 2, 32'h28, 0, 32'hA2A2A2A2, 0);
    add(SQ, 0, 2, 32'h2C, 0, 32'hA3A3A3A3, 0);
    run_prog(0);
    hburst = 3'b000;
    add(NS, 0, 2, 32'h30, 0, 32'h30303030, 0);
    run_prog(0);

    // out-of-range and oversize accesses
    add(NS, 1, 2, 32'h0, 32'h0BADF00D, 0, 0);
    add(NS, 1, 2, 32'h4, 32'h44444444, 0, 0);
    add(NS, 1, 2, 32'h1000, 32'h55555555, 0, ERR);
    add(NS, 0, 2, 32'h1000, 0, 0, ERR);
    add(NS, 0, 2, 32'h0, 0, 32'h0BADF00D, 0);
    add(NS, 1, 3, 32'h4, 32'h77777777, 0, ERR);
    add(NS, 0, 2, 32'h4, 0,
        ERR_EN ? 32'h44444444 : 32'h77777777, 0);
    add(NS, 0, 3, 32'h0, 0,
        ERR_EN ? 32'h0 : 32'h0BADF00D, ERR);
    run_prog(0);

    // three-wait slave: byte lane and error timing
    sel = 1'b1;
    add(NS, 1, 2, 32'h10, 32'h11223344, 0, 0);
    add(NS, 1, 0, 32'h13, 32'hAAAAAAAA, 0, 0);
    add(NS, 0, 2, 32'h10, 0, 32'hAA223344, 0);
    add(NS, 1, 2, 32'h40, 32'h12345678, 0, 0);
    add(NS, 0, 2, 32'h1000, 0, 0, ERR);
    add(NS, 0, 2, 32'h40, 0, 32'h12345678, 0);
    run_prog(3);

    // reset during the second wait cycle of a write
    htrans = NS;
    hwrite = 1'b1;
    hsize  = 3'd2;
    haddr  = 32'h40;
    @(posedge hclk);
    #1;
    htrans = IDL;
    hwrite = 1'b0;
    hwdata = 32'hCAFEF00D;
    @(posedge hclk);
    #1;
    chk("abort_stall", {31'd0, rdy}, 32'd0);
    hresetn = 1'b0;
    #1;
    chk("abort_ready", {31'd0, rdy}, 32'd1);
    chk("abort_resp", {30'd0, resp}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    hwdata  = '0;
    @(posedge hclk);
    #1;
    add(NS, 0, 2, 32'h40, 0, 32'h12345678, 0);
    run_prog(3);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
